// File: rtl/value_checker.sv
// Sequence checker for an incrementing count stream: syncs, locks after a run of
// correct increments, counts mismatches and wrap-arounds while locked.
module value_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned UNLOCK_ERRS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [15:0]      wrap_count,
  output logic [WIDTH-1:0] last_value
);

  localparam int unsigned GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = (UNLOCK_ERRS < 1) ? 1 : $clog2(UNLOCK_ERRS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state,      state_nx;
  logic [GW-1:0]    good_run,   good_run_nx;
  logic [BW-1:0]    bad_run,    bad_run_nx;
  logic             locked_nx;
  logic             err_pulse_nx;
  logic [15:0]      err_count_nx;
  logic [15:0]      wrap_count_nx;
  logic [WIDTH-1:0] last_value_nx;

  logic             match_c;
  logic [GW-1:0]    good_inc_c;
  logic [BW-1:0]    bad_inc_c;

  assign match_c    = (value == WIDTH'(last_value + 1'b1));
  assign good_inc_c = GW'(good_run + 1'b1);
  assign bad_inc_c  = BW'(bad_run + 1'b1);

  // State and output registers; synchronous active-low reset wins over valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      good_run   <= '0;
      bad_run    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      last_value <= '0;
    end else begin
      state      <= state_nx;
      good_run   <= good_run_nx;
      bad_run    <= bad_run_nx;
      locked     <= locked_nx;
      err_pulse  <= err_pulse_nx;
      err_count  <= err_count_nx;
      wrap_count <= wrap_count_nx;
      last_value <= last_value_nx;
    end
  end

  // Next-state and next-output logic; everything holds unless a valid sample arrives
  always_comb begin
    state_nx      = state;
    good_run_nx   = good_run;
    bad_run_nx    = bad_run;
    err_pulse_nx  = 1'b0;
    err_count_nx  = err_count;
    wrap_count_nx = wrap_count;
    last_value_nx = last_value;

    if (valid) begin
      last_value_nx = value;
      case (state)
        IDLE: begin
          good_run_nx = '0;
          state_nx    = SYNC;
        end
        SYNC: begin
          if (match_c) begin
            good_run_nx = good_inc_c;
            if (good_inc_c == GW'(LOCK_COUNT)) begin
              state_nx   = LOCKED;
              bad_run_nx = '0;
            end
          end else begin
            good_run_nx = '0;
          end
        end
        LOCKED: begin
          if (match_c) begin
            bad_run_nx = '0;
            // A match onto zero can only come from all-ones
            if (value == '0) begin
              wrap_count_nx = 16'(wrap_count + 1'b1);
            end
          end else begin
            err_pulse_nx = 1'b1;
            if (err_count != 16'hFFFF) begin
              err_count_nx = 16'(err_count + 1'b1);
            end
            bad_run_nx = bad_inc_c;
            if (bad_inc_c == BW'(UNLOCK_ERRS)) begin
              state_nx    = SYNC;
              good_run_nx = '0;
              bad_run_nx  = '0;
            end
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    locked_nx = (state_nx == LOCKED);
  end

endmodule
